// File: rtl/keypad_code_lock.sv
// Debounces raw keypad scanner codes into press events, gathers a 4-digit BCD entry and checks it against PASSCODE.
// Press events appear DEBOUNCE_CYCLES+2 cycles after a code change; there is no backpressure, and presses outside IDLE only pulse key_event.
module keypad_code_lock #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic [15:0] PASSCODE        = 16'h1234,
  parameter int unsigned UNLOCK_CYCLES   = 250000000,
  parameter int unsigned ERR_CYCLES      = 25000000,
  parameter int unsigned MAX_FAIL        = 3,
  parameter int unsigned LOCKOUT_CYCLES  = 1500000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  key_code,
  output logic        key_event,
  output logic [3:0]  key_value,
  output logic [15:0] entry_digits,
  output logic [2:0]  entry_count,
  output logic        unlock,
  output logic        error,
  output logic        locked_out
);

  localparam logic [15:0] DB_LAST      = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] UNLOCK_LAST  = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0] ERR_LAST     = 32'(ERR_CYCLES - 1);
  localparam logic [31:0] LOCKOUT_LAST = 32'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]  FAIL_LIMIT   = 3'(MAX_FAIL);

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] NO_KEY    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_UNLOCKED,
    S_FAIL,
    S_LOCKOUT
  } state_t;

  function automatic logic is_key(input logic [3:0] code);
    return code <= KEY_ENTER;
  endfunction

  logic [3:0]  sample_q;
  logic [15:0] db_cnt;
  logic [3:0]  stable;
  logic [3:0]  stable_prev;
  logic        press;

  // A press is a stable transition from any no-key code to a real key.
  assign press = is_key(stable) && !is_key(stable_prev);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_q    <= NO_KEY;
      db_cnt      <= '0;
      stable      <= NO_KEY;
      stable_prev <= NO_KEY;
      key_event   <= 1'b0;
      key_value   <= 4'h0;
    end else begin
      sample_q <= key_code;
      if (key_code != sample_q) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_LAST) begin
        db_cnt <= db_cnt + 16'd1;
      end
      if ((key_code == sample_q) && (db_cnt == DB_LAST)) begin
        stable <= sample_q;
      end
      stable_prev <= stable;
      key_event   <= press;
      if (press) begin
        key_value <= stable;
      end
    end
  end

  state_t      state, state_d;
  logic [31:0] timer, timer_d;
  logic [15:0] digits_d;
  logic [2:0]  count_d;
  logic [2:0]  fail_cnt, fail_d, fail_inc;

  always_comb begin
    state_d  = state;
    timer_d  = timer;
    digits_d = entry_digits;
    count_d  = entry_count;
    fail_d   = fail_cnt;
    fail_inc = fail_cnt + 3'd1;
    case (state)
      S_IDLE: begin
        if (key_event) begin
          if (key_value <= 4'd9) begin
            if (entry_count < 3'd4) begin
              digits_d = {entry_digits[11:0], key_value};
              count_d  = entry_count + 3'd1;
            end
          end else if (key_value == KEY_CLEAR) begin
            digits_d = '0;
            count_d  = '0;
          end else if (key_value == KEY_ENTER) begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        digits_d = '0;
        count_d  = '0;
        timer_d  = '0;
        if ((entry_count == 3'd4) && (entry_digits == PASSCODE)) begin
          state_d = S_UNLOCKED;
          fail_d  = '0;
        end else begin
          fail_d  = fail_inc;
          state_d = (fail_inc == FAIL_LIMIT) ? S_LOCKOUT : S_FAIL;
        end
      end
      S_UNLOCKED: begin
        if (timer == UNLOCK_LAST) state_d = S_IDLE;
        else                      timer_d = timer + 32'd1;
      end
      S_FAIL: begin
        if (timer == ERR_LAST) state_d = S_IDLE;
        else                   timer_d = timer + 32'd1;
      end
      S_LOCKOUT: begin
        if (timer == LOCKOUT_LAST) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          timer_d = timer + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered copies of the next state, so they rise the cycle after CHECK.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      timer        <= '0;
      entry_digits <= '0;
      entry_count  <= '0;
      fail_cnt     <= '0;
      unlock       <= 1'b0;
      error        <= 1'b0;
      locked_out   <= 1'b0;
    end else begin
      state        <= state_d;
      timer        <= timer_d;
      entry_digits <= digits_d;
      entry_count  <= count_d;
      fail_cnt     <= fail_d;
      unlock       <= (state_d == S_UNLOCKED);
      error        <= (state_d == S_FAIL);
      locked_out   <= (state_d == S_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_keypad_code_lock.sv
// Bench for keypad_code_lock: table of code entries, hand-written corner sequences, random key traffic vs a timeline model.
module tb_keypad_code_lock;

  localparam int D  = 4;
  localparam int U  = 8;
  localparam int E  = 6;
  localparam int MF = 3;
  localparam int L  = 40;
  localparam logic [15:0] PASS = 16'h1234;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  key_code = 4'hF;
  logic        key_event;
  logic [3:0]  key_value;
  logic [15:0] entry_digits;
  logic [2:0]  entry_count;
  logic        unlock, error, locked_out;

  keypad_code_lock #(
    .DEBOUNCE_CYCLES(D), .PASSCODE(PASS), .UNLOCK_CYCLES(U),
    .ERR_CYCLES(E), .MAX_FAIL(MF), .LOCKOUT_CYCLES(L)
  ) dut (
    .clock(clock), .reset_n(reset_n), .key_code(key_code),
    .key_event(key_event), .key_value(key_value),
    .entry_digits(entry_digits), .entry_count(entry_count),
    .unlock(unlock), .error(error), .locked_out(locked_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: run-length debounce plus a timeline of the last verdict.
  int          n = 0;
  int          idle_from, clr_at, act_start, act_len, act_kind, fails, rl;
  logic [3:0]  rv, s1, s2, m_kv;
  logic        m_ev;
  logic [15:0] m_digits;
  int          m_count;

  function automatic bit is_key(input logic [3:0] v);
    return v <= 4'hB;
  endfunction

  task automatic model_reset();
    idle_from = 0; clr_at = -1; act_start = 0; act_len = 0; act_kind = 0;
    fails = 0; rv = 4'hF; rl = 1; s1 = 4'hF; s2 = 4'hF;
    m_kv = 4'h0; m_ev = 1'b0; m_digits = 16'h0; m_count = 0;
  endtask

  function automatic logic m_out(input int kind);
    return (act_kind == kind) && (n >= act_start) && (n < act_start + act_len);
  endfunction

  task automatic model_step();
    logic old_ev, new_ev;
    logic [3:0] old_kv;
    if (!reset_n) begin
      model_reset();
      return;
    end
    n++;
    old_ev = m_ev;
    old_kv = m_kv;
    if (n == clr_at) begin
      m_digits = 16'h0;
      m_count  = 0;
    end
    if (old_ev && n >= idle_from) begin
      if (old_kv <= 4'd9) begin
        if (m_count < 4) begin
          m_digits = {m_digits[11:0], old_kv};
          m_count++;
        end
      end else if (old_kv == 4'hA) begin
        m_digits = 16'h0;
        m_count  = 0;
      end else begin
        if (m_count == 4 && m_digits == PASS) begin
          act_kind = 1; act_len = U; fails = 0;
        end else begin
          fails++;
          if (fails == MF) begin
            act_kind = 3; act_len = L; fails = 0;
          end else begin
            act_kind = 2; act_len = E;
          end
        end
        act_start = n + 1;
        idle_from = n + act_len + 2;
        clr_at    = n + 1;
      end
    end
    if (key_code == rv) begin
      if (rl <= D) rl++;
    end else begin
      rv = key_code;
      rl = 1;
    end
    new_ev = is_key(s1) && !is_key(s2);
    if (new_ev) m_kv = s1;
    m_ev = new_ev;
    s2 = s1;
    if (rl >= D + 1) s1 = rv;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check($sformatf("model_cycle%0d", n),
          32'({key_event, key_value, entry_digits, entry_count, unlock, error, locked_out}),
          32'({m_ev, m_kv, m_digits, 3'(m_count), m_out(1), m_out(2), m_out(3)}));
  endtask

  task automatic press(input logic [3:0] k);
    key_code = k;
    repeat (D + 4) tick();
    key_code = 4'hF;
    repeat (D + 4) tick();
  endtask

  task automatic enter_until_rise(output int kind, output int lat);
    kind = 0;
    lat  = 0;
    key_code = 4'hB;
    for (int i = 1; i <= 60 && kind == 0; i++) begin
      tick();
      lat = i;
      if (unlock) kind = 1;
      else if (error) kind = 2;
      else if (locked_out) kind = 3;
    end
  endtask

  task automatic enter_measure(output int kind, output int lat, output int len);
    bit high;
    enter_until_rise(kind, lat);
    len  = (kind != 0) ? 1 : 0;
    high = (kind != 0);
    while (high && len < 200) begin
      tick();
      high = (kind == 1) ? unlock : (kind == 2) ? error : locked_out;
      if (high) len++;
    end
    key_code = 4'hF;
    repeat (D + 4) tick();
  endtask

  task automatic async_reset(input string name);
    #1 reset_n = 1'b0;
    model_reset();
    #1 check(name, 32'({key_event, key_value, entry_digits, entry_count, unlock, error, locked_out}), 32'd0);
    key_code = 4'hF;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  typedef struct {
    logic [31:0] keys;        // first key in [31:28]
    int          nkeys;
    logic [15:0] exp_digits;
    int          exp_count;
    int          exp_kind;    // 1 unlock, 2 error, 3 lockout
    int          exp_len;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int kind, lat, len, nev, first_ev;
    logic [3:0] kv;
    logic [3:0] k;
    int r;

    tbl[0] = '{32'h1234_0000, 4, 16'h1234, 4, 1, U};
    tbl[1] = '{32'h1235_0000, 4, 16'h1235, 4, 2, E};
    tbl[2] = '{32'h1200_0000, 2, 16'h0012, 2, 2, E};
    tbl[3] = '{32'h9999_0000, 4, 16'h9999, 4, 3, L};
    tbl[4] = '{32'h1234_0000, 4, 16'h1234, 4, 1, U};
    tbl[5] = '{32'h1234_9000, 5, 16'h1234, 4, 1, U};
    tbl[6] = '{32'hA400_0000, 2, 16'h0004, 1, 2, E};
    tbl[7] = '{32'h12A0_0000, 3, 16'h0000, 0, 2, E};

    model_reset();
    repeat (3) tick();
    check("reset_outputs", 32'({key_event, key_value, entry_digits, entry_count, unlock, error, locked_out}), 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    // Debounce: one event D+2 cycles after the change, then a short glitch.
    nev = 0; first_ev = 0; kv = 4'h0;
    key_code = 4'h5;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (key_event) begin
        nev++;
        if (first_ev == 0) first_ev = i;
        kv = key_value;
      end
    end
    key_code = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (key_event) nev++;
    end
    check("db_event_count", 32'(nev), 32'd1);
    check("db_latency", 32'(first_ev), 32'(D + 2));
    check("db_value", 32'(kv), 32'h5);

    nev = 0;
    key_code = 4'h7;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (key_event) nev++;
    end
    key_code = 4'hF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (key_event) nev++;
    end
    check("glitch_events", 32'(nev), 32'd0);

    press(4'hA);
    check("clear_count", 32'(entry_count), 32'd0);

    foreach (tbl[t]) begin
      for (int j = 0; j < tbl[t].nkeys; j++) begin
        k = tbl[t].keys[31 - 4 * j -: 4];
        press(k);
      end
      check($sformatf("vec%0d_digits", t), 32'(entry_digits), 32'(tbl[t].exp_digits));
      check($sformatf("vec%0d_count", t), 32'(entry_count), 32'(tbl[t].exp_count));
      enter_measure(kind, lat, len);
      check($sformatf("vec%0d_kind", t), 32'(kind), 32'(tbl[t].exp_kind));
      check($sformatf("vec%0d_latency", t), 32'(lat), 32'(D + 4));
      check($sformatf("vec%0d_length", t), 32'(len), 32'(tbl[t].exp_len));
      check($sformatf("vec%0d_entry_cleared", t), 32'(entry_count), 32'd0);
    end

    // Two failures are pending, so one short code locks; a digit during lockout is ignored.
    enter_until_rise(kind, lat);
    check("lockout_on_third_fail", 32'(kind), 32'd3);
    key_code = 4'hF;
    repeat (D + 4) tick();
    nev = 0; kv = 4'h0;
    key_code = 4'h5;
    for (int i = 0; i < D + 4; i++) begin
      tick();
      if (key_event) begin
        nev++;
        kv = key_value;
      end
    end
    check("lockout_key_event", 32'(nev), 32'd1);
    check("lockout_key_value", 32'(kv), 32'h5);
    check("lockout_entry_count", 32'(entry_count), 32'd0);
    check("lockout_entry_digits", 32'(entry_digits), 32'd0);
    check("lockout_still_active", 32'(locked_out), 32'd1);
    key_code = 4'hF;
    for (int i = 0; i < 100 && locked_out; i++) tick();
    check("lockout_released", 32'(locked_out), 32'd0);
    repeat (2) tick();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    enter_measure(kind, lat, len);
    check("unlock_after_lockout", 32'(kind), 32'd1);

    // Async reset in the middle of UNLOCKED, then of LOCKOUT.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    enter_until_rise(kind, lat);
    check("mid_unlock_reached", 32'(kind), 32'd1);
    repeat (3) tick();
    async_reset("reset_mid_unlock");

    for (int a = 0; a < 2; a++) begin
      enter_measure(kind, lat, len);
      check($sformatf("short_code_error%0d", a), 32'(kind), 32'd2);
    end
    enter_until_rise(kind, lat);
    check("mid_lockout_reached", 32'(kind), 32'd3);
    repeat (5) tick();
    async_reset("reset_mid_lockout");

    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    enter_measure(kind, lat, len);
    check("unlock_after_reset_kind", 32'(kind), 32'd1);
    check("unlock_after_reset_len", 32'(len), 32'(U));

    // Random key traffic, including glitches and key-to-key changes.
    for (int s = 0; s < 500; s++) begin
      if ($urandom_range(0, 29) == 0) begin
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hB);
      end else begin
        r = int'($urandom_range(0, 19));
        key_code = (r > 15) ? 4'hF : r[3:0];
        repeat ($urandom_range(1, D + 4)) tick();
      end
    end
    key_code = 4'hF;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
